// File: rtl/spart_echo_controller.sv
// SPART echo controller: programs the baud divisor selected by br_cfg, then
// echoes every received byte back out, reprogramming whenever br_cfg changes.
module spart_echo_controller #(
    parameter logic [15:0] DIV_0 = 16'h0515,
    parameter logic [15:0] DIV_1 = 16'h028A,
    parameter logic [15:0] DIV_2 = 16'h0145,
    parameter logic [15:0] DIV_3 = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    input  logic [7:0] databus_in,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] databus_out,
    output logic       databus_oe,
    output logic       cfg_done,
    output logic [7:0] echo_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CFG_LO  = 3'd1,
        CFG_HI  = 3'd2,
        WAIT_RX = 3'd3,
        READ    = 3'd4,
        WAIT_TX = 3'd5,
        WRITE   = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cfg_q_reg, cfg_q_next;
    logic [7:0]  rx_byte_reg, rx_byte_next;
    logic [7:0]  echo_count_reg, echo_count_next;
    logic        cfg_done_reg, cfg_done_next;
    logic [15:0] div_table [4];
    logic [15:0] divisor;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_div
            localparam logic [15:0] DIV_SEL = (gi == 0) ? DIV_0 :
                                              (gi == 1) ? DIV_1 :
                                              (gi == 2) ? DIV_2 : DIV_3;
            assign div_table[gi] = DIV_SEL;
        end
    endgenerate

    // Both divisor bytes come from the latched selection, never live br_cfg.
    assign divisor = div_table[cfg_q_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cfg_q_reg      <= 2'b00;
            rx_byte_reg    <= 8'h00;
            echo_count_reg <= 8'h00;
            cfg_done_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cfg_q_reg      <= cfg_q_next;
            rx_byte_reg    <= rx_byte_next;
            echo_count_reg <= echo_count_next;
            cfg_done_reg   <= cfg_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cfg_q_next      = cfg_q_reg;
        rx_byte_next    = rx_byte_reg;
        echo_count_next = echo_count_reg;
        cfg_done_next   = cfg_done_reg;
        iocs            = 1'b0;
        iorw            = 1'b0;
        ioaddr          = 2'b00;
        databus_out     = 8'h00;
        databus_oe      = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = CFG_LO;
            end
            CFG_LO: begin
                iocs        = 1'b1;
                ioaddr      = 2'b10;
                databus_out = divisor[7:0];
                databus_oe  = 1'b1;
                state_next  = CFG_HI;
            end
            CFG_HI: begin
                iocs          = 1'b1;
                ioaddr        = 2'b11;
                databus_out   = divisor[15:8];
                databus_oe    = 1'b1;
                cfg_done_next = 1'b1;
                state_next    = WAIT_RX;
            end
            WAIT_RX: begin
                // A rate change outranks pending receive data.
                if (br_cfg != cfg_q_reg) begin
                    cfg_done_next = 1'b0;
                    state_next    = CFG_LO;
                end else if (rda) begin
                    state_next = READ;
                end
            end
            READ: begin
                iocs         = 1'b1;
                iorw         = 1'b1;
                rx_byte_next = databus_in;
                state_next   = WAIT_TX;
            end
            WAIT_TX: begin
                if (tbr) state_next = WRITE;
            end
            WRITE: begin
                iocs            = 1'b1;
                databus_out     = rx_byte_reg;
                databus_oe      = 1'b1;
                echo_count_next = echo_count_reg + 8'd1;
                state_next      = WAIT_RX;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if ((state_next == CFG_LO) && (state_reg != CFG_LO))
            cfg_q_next = br_cfg;
    end

    assign cfg_done   = cfg_done_reg;
    assign echo_count = echo_count_reg;

endmodule

// File: tb/tb_spart_echo_controller.sv
// Directed bench for spart_echo_controller; expected bus values are hand-derived.
module tb_spart_echo_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic [7:0] databus_in;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus_out;
    logic       databus_oe;
    logic       cfg_done;
    logic [7:0] echo_count;

    int tests_run = 0;
    int tests_failed = 0;
    int strobes;

    always #5 clk = ~clk;

    spart_echo_controller dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .databus_in (databus_in),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus_out(databus_out),
        .databus_oe (databus_oe),
        .cfg_done   (cfg_done),
        .echo_count (echo_count)
    );

    // Bus snapshot: {iocs, iorw, ioaddr, databus_oe, databus_out}
    function automatic logic [12:0] bus_now();
        return {iocs, iorw, ioaddr, databus_oe, databus_out};
    endfunction

    function automatic logic [12:0] mk_bus(input logic cs, input logic rw,
                                           input logic [1:0] addr, input logic oe,
                                           input logic [7:0] data);
        return {cs, rw, addr, oe, data};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        br_cfg = 2'b01;
        rda = 1'b0;
        tbr = 1'b0;
        databus_in = 8'h00;
        step();
        step();
        check_eq("reset_bus", 32'(bus_now()), 32'h0);
        check_eq("reset_cfg_done", 32'(cfg_done), 32'h0);
        check_eq("reset_echo_count", 32'(echo_count), 32'h0);

        // Configuration after reset release, br_cfg=01
        rst = 1'b1;
        check_eq("idle_bus", 32'(bus_now()), 32'h0);
        step();
        check_eq("cfg_lo_01", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b10, 1'b1, 8'h8A)));
        check_eq("cfg_lo_done", 32'(cfg_done), 32'h0);
        step();
        check_eq("cfg_hi_01", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b11, 1'b1, 8'h02)));
        step();
        check_eq("wait_rx_bus", 32'(bus_now()), 32'h0);
        check_eq("cfg_done_set", 32'(cfg_done), 32'h1);
        $display("[TB] config br_cfg=01 divisor 0x028A");

        // Minimum-latency echo of 0x41
        rda = 1'b1; tbr = 1'b1; databus_in = 8'h41;
        step();
        check_eq("read_strobe", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b1, 2'b00, 1'b0, 8'h00)));
        rda = 1'b0;
        step();
        databus_in = 8'h00;
        check_eq("wait_tx_bus", 32'(bus_now()), 32'h0);
        step();
        check_eq("write_41", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b00, 1'b1, 8'h41)));
        check_eq("echo_before_inc", 32'(echo_count), 32'h0);
        step();
        check_eq("echo_count_1", 32'(echo_count), 32'h1);
        $display("[TB] echo 0x41 count=%0d", echo_count);

        // Transmitter stalled for 10 cycles
        rda = 1'b1; tbr = 1'b0; databus_in = 8'h5A;
        step();
        check_eq("read_5a", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b1, 2'b00, 1'b0, 8'h00)));
        rda = 1'b0;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (iocs) strobes++;
        end
        check_eq("stall_no_strobe", 32'(strobes), 32'h0);
        tbr = 1'b1;
        step();
        check_eq("write_5a", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b00, 1'b1, 8'h5A)));
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (iocs) strobes++;
        end
        check_eq("single_write", 32'(strobes), 32'h0);
        check_eq("echo_count_2", 32'(echo_count), 32'h2);
        $display("[TB] echo 0x5A after stall count=%0d", echo_count);

        // br_cfg changes while waiting to transmit
        rda = 1'b1; tbr = 1'b0; databus_in = 8'h77;
        step();
        check_eq("read_77", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b1, 2'b00, 1'b0, 8'h00)));
        rda = 1'b0; br_cfg = 2'b11;
        step();
        check_eq("wait_tx_ignores_cfg", 32'(bus_now()), 32'h0);
        tbr = 1'b1;
        step();
        check_eq("write_77", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b00, 1'b1, 8'h77)));
        step();
        check_eq("wait_rx_before_recfg", 32'(bus_now()), 32'h0);
        step();
        check_eq("cfg_lo_11", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b10, 1'b1, 8'hA2)));
        check_eq("cfg_done_cleared", 32'(cfg_done), 32'h0);
        step();
        check_eq("cfg_hi_11", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b11, 1'b1, 8'h00)));
        check_eq("cfg_done_low_hi", 32'(cfg_done), 32'h0);
        step();
        check_eq("cfg_done_reset", 32'(cfg_done), 32'h1);
        check_eq("echo_count_3", 32'(echo_count), 32'h3);
        $display("[TB] echo 0x77 then config br_cfg=11 count=%0d", echo_count);

        // Rate change and rda together: reconfigure wins
        br_cfg = 2'b00; rda = 1'b1; tbr = 1'b1; databus_in = 8'h33;
        step();
        check_eq("prio_cfg_lo_00", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b10, 1'b1, 8'h15)));
        step();
        check_eq("prio_cfg_hi_00", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b11, 1'b1, 8'h05)));
        step();
        check_eq("prio_wait_rx", 32'(bus_now()), 32'h0);
        step();
        check_eq("prio_read", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b1, 2'b00, 1'b0, 8'h00)));
        rda = 1'b0;
        step();
        step();
        check_eq("prio_write_33", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b00, 1'b1, 8'h33)));
        step();
        check_eq("echo_count_4", 32'(echo_count), 32'h4);
        $display("[TB] reconfig br_cfg=00 then echo 0x33 count=%0d", echo_count);

        // Counter wrap: 251 more echoes to 255, one more to 0
        for (int i = 0; i < 252; i++) begin
            rda = 1'b1; databus_in = 8'(i);
            step();
            rda = 1'b0;
            step();
            step();
            step();
            if (i == 250) check_eq("echo_count_255", 32'(echo_count), 32'hFF);
        end
        check_eq("echo_count_wrap", 32'(echo_count), 32'h0);
        $display("[TB] echo counter wrapped count=%0d", echo_count);

        // Reset during CFG_HI
        br_cfg = 2'b01;
        step();
        step();
        check_eq("cfg_hi_pre_reset", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b11, 1'b1, 8'h02)));
        rst = 1'b0;
        #1;
        check_eq("async_reset_bus", 32'(bus_now()), 32'h0);
        step();
        check_eq("reset_hold_bus", 32'(bus_now()), 32'h0);
        check_eq("reset_hold_done", 32'(cfg_done), 32'h0);
        rst = 1'b1;
        step();
        check_eq("restart_cfg_lo", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b10, 1'b1, 8'h8A)));
        step();
        check_eq("restart_cfg_hi", 32'(bus_now()), 32'(mk_bus(1'b1, 1'b0, 2'b11, 1'b1, 8'h02)));
        step();
        check_eq("restart_cfg_done", 32'(cfg_done), 32'h1);
        $display("[TB] reset during CFG_HI, sequence restarted");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spart_echo_controller.md
SPART_ECHO_CONTROLLER -- requirements
Module: spart_echo_controller

Interface
REQ-001 SHALL have parameter DIV_0, default 16'h0515, meaning divisor for br_cfg=00 (4800 baud).
REQ-002 SHALL have parameter DIV_1, default 16'h028A, meaning divisor for br_cfg=01 (9600 baud).
REQ-003 SHALL have parameter DIV_2, default 16'h0145, meaning divisor for br_cfg=10 (19200 baud).
REQ-004 SHALL have parameter DIV_3, default 16'h00A2, meaning divisor for br_cfg=11 (38400 baud).
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port br_cfg  input  2  baud-rate select, quasi-static.
REQ-008 SHALL have port rda  input  1  SPART receive-data-available.
REQ-009 SHALL have port tbr  input  1  SPART transmit-buffer-ready.
REQ-010 SHALL have port databus_in  input  8  read data from the SPART.
REQ-011 SHALL have port iocs  output  1  bus-access strobe, one cycle per access.
REQ-012 SHALL have port iorw  output  1  1 = read, 0 = write.
REQ-013 SHALL have port ioaddr  output  2  00 tx/rx buffer, 01 status, 10 divisor low, 11 divisor high.
REQ-014 SHALL have port databus_out  output  8  write data to the SPART.
REQ-015 SHALL have port databus_oe  output  1  high while databus_out is driven.
REQ-016 SHALL have port cfg_done  output  1  divisor programmed and matches cfg_q.
REQ-017 SHALL have port echo_count  output  8  number of bytes echoed, mod 256.

Function
REQ-018 SHALL implement states IDLE, CFG_LO, CFG_HI, WAIT_RX, READ, WAIT_TX, WRITE; one state register.
REQ-019 IDLE SHALL go to CFG_LO unconditionally in the next cycle.
REQ-020 On every entry to CFG_LO, cfg_q SHALL load br_cfg; the divisor SHALL be DIV_<cfg_q>, so both bytes come from one selection.
REQ-021 CFG_LO SHALL output iocs=1, iorw=0, ioaddr=10, databus_out=divisor[7:0], databus_oe=1, then go to CFG_HI.
REQ-022 CFG_HI SHALL output iocs=1, iorw=0, ioaddr=11, databus_out=divisor[15:8], databus_oe=1, then go to WAIT_RX; cfg_done SHALL be set on this transition.
REQ-023 WAIT_RX SHALL go to CFG_LO if br_cfg != cfg_q, with priority over rda; cfg_done SHALL clear on that transition.
REQ-024 Otherwise WAIT_RX SHALL go to READ when rda=1, else stay; all bus outputs SHALL be 0.
REQ-025 READ SHALL output iocs=1, iorw=1, ioaddr=00, databus_oe=0; rx_byte SHALL capture databus_in at the end of this cycle; next state WAIT_TX.
REQ-026 WAIT_TX SHALL go to WRITE when tbr=1, else stay; br_cfg changes SHALL NOT be acted on until WAIT_RX.
REQ-027 WRITE SHALL output iocs=1, iorw=0, ioaddr=00, databus_out=rx_byte, databus_oe=1; echo_count SHALL increment, wrapping 255->0; next state WAIT_RX.
REQ-028 Bus outputs SHALL be Moore decodes of state only; iocs SHALL be high for exactly one cycle per access.
REQ-029 databus_oe SHALL be 0 in every state except CFG_LO, CFG_HI and WRITE; databus_out SHALL be 8'h00 when databus_oe=0.
REQ-030 Minimum echo latency: rda sampled high in WAIT_RX -> READ next cycle -> WRITE two cycles after READ if tbr=1.

Reset
REQ-031 rst low SHALL immediately force state IDLE, cfg_q=00, rx_byte=00, echo_count=00, cfg_done=0, iocs=0, iorw=0, ioaddr=00, databus_out=00, databus_oe=0.
REQ-032 Reset asserted mid-access (any state) SHALL abort it with no further strobe; after release the full CFG_LO/CFG_HI sequence SHALL repeat.

Verification
REQ-033 Release reset, br_cfg=01 -> cycle 2 write 10/8'h8A, cycle 3 write 11/8'h02, cfg_done=1 from cycle 4.
REQ-034 rda=1, databus_in=8'h41, tbr=1 -> READ strobe, then WRITE 00/8'h41, echo_count 0->1.
REQ-035 rda=1, tbr=0 for 10 cycles -> stays in WAIT_TX, iocs=0; tbr=1 -> one WRITE strobe only.
REQ-036 br_cfg 01->11 while in WAIT_TX -> echo completes first, then writes 10/8'hA2, 11/8'h00; cfg_done low between.
REQ-037 br_cfg change and rda=1 together in WAIT_RX -> reconfigure first, READ after CFG_HI.
REQ-038 256 echoes -> echo_count wraps to 8'h00; rst low during CFG_HI -> outputs zero at once, sequence restarts.
